// File: rtl/sat_decide_unit.sv
// DPLL decision/backtrack controller feeding bcp_top: decides the lowest free variable,
// hands the partial assignment to BCP and walks a decision trail on conflict.
module sat_decide_unit #(
  parameter int VAR_NUM     = 4,
  parameter int VAR_NUM_LOG = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VAR_NUM-1:0] free_in,
  input  logic [VAR_NUM-1:0] assign_in,
  input  logic               bcp_done,
  input  logic               bcp_conflict,
  output logic [VAR_NUM-1:0] free_out,
  output logic [VAR_NUM-1:0] assignment_out,
  output logic               bcp_request,
  output logic               busy,
  output logic               sat,
  output logic               unsat
);

  localparam int SPW = VAR_NUM_LOG + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_WAIT_BCP,
    S_BACKTRACK,
    S_DONE_SAT,
    S_DONE_UNSAT
  } state_e;

  state_e             state_q, state_d;
  logic [VAR_NUM-1:0] free_q, free_d;
  logic [VAR_NUM-1:0] assign_q, assign_d;
  logic               bcp_req_q, bcp_req_d;
  logic               busy_q, busy_d;
  logic               sat_q, sat_d;
  logic               unsat_q, unsat_d;
  logic [SPW-1:0]     sp_q, sp_d;

  logic [VAR_NUM_LOG-1:0] tvar_q    [VAR_NUM];
  logic [VAR_NUM_LOG-1:0] tvar_d    [VAR_NUM];
  logic [VAR_NUM-1:0]     tfree_q   [VAR_NUM];
  logic [VAR_NUM-1:0]     tfree_d   [VAR_NUM];
  logic [VAR_NUM-1:0]     tassign_q [VAR_NUM];
  logic [VAR_NUM-1:0]     tassign_d [VAR_NUM];
  logic [VAR_NUM-1:0]     tflip_q, tflip_d;
  logic [VAR_NUM-1:0]     tvalid_q, tvalid_d;

  logic [VAR_NUM_LOG-1:0] low_idx, push_idx, top_idx, top_var;
  logic [VAR_NUM-1:0]     low_mask, top_mask;
  logic                   found;

  always_comb begin : pick
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < VAR_NUM; i++) begin
      if (free_q[i] && !found) begin
        low_idx = VAR_NUM_LOG'(i);
        found   = 1'b1;
      end
    end
    push_idx = VAR_NUM_LOG'(sp_q);
    top_idx  = VAR_NUM_LOG'(sp_q - SPW'(1));
    top_var  = tvar_q[top_idx];
    low_mask = '0;
    low_mask[low_idx] = 1'b1;
    top_mask = '0;
    top_mask[top_var] = 1'b1;
  end

  always_comb begin : next_state
    state_d   = state_q;
    free_d    = free_q;
    assign_d  = assign_q;
    bcp_req_d = 1'b0;
    busy_d    = busy_q;
    sat_d     = sat_q;
    unsat_d   = unsat_q;
    sp_d      = sp_q;
    tvar_d    = tvar_q;
    tfree_d   = tfree_q;
    tassign_d = tassign_q;
    tflip_d   = tflip_q;
    tvalid_d  = tvalid_q;

    unique case (state_q)
      S_IDLE, S_DONE_SAT, S_DONE_UNSAT: begin
        if (start) begin
          free_d   = free_in;
          assign_d = assign_in;
          sp_d     = '0;
          tvalid_d = '0;
          tflip_d  = '0;
          sat_d    = 1'b0;
          unsat_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (free_q == '0) begin
          sat_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE_SAT;
        end else begin
          tvar_d[push_idx]    = low_idx;
          tfree_d[push_idx]   = free_q;
          tassign_d[push_idx] = assign_q;
          tflip_d[push_idx]   = 1'b0;
          tvalid_d[push_idx]  = 1'b1;
          sp_d      = sp_q + SPW'(1);
          free_d    = free_q & ~low_mask;
          assign_d  = assign_q | low_mask;
          bcp_req_d = 1'b1;
          state_d   = S_WAIT_BCP;
        end
      end
      S_WAIT_BCP: begin
        // bcp_req_q marks the first wait cycle, in which bcp_done is not yet trusted
        if (!bcp_req_q && bcp_done) begin
          if (bcp_conflict) begin
            state_d = S_BACKTRACK;
          end else begin
            free_d   = free_in;
            assign_d = assign_in;
            state_d  = S_DECIDE;
          end
        end
      end
      S_BACKTRACK: begin
        if (sp_q == '0) begin
          unsat_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE_UNSAT;
        end else if (!tflip_q[top_idx]) begin
          free_d   = tfree_q[top_idx] & ~top_mask;
          assign_d = tassign_q[top_idx] & ~top_mask;
          tflip_d[top_idx] = 1'b1;
          bcp_req_d = 1'b1;
          state_d   = S_WAIT_BCP;
        end else begin
          tvalid_d[top_idx] = 1'b0;
          sp_d = sp_q - SPW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      free_q    <= '0;
      assign_q  <= '0;
      bcp_req_q <= 1'b0;
      busy_q    <= 1'b0;
      sat_q     <= 1'b0;
      unsat_q   <= 1'b0;
      sp_q      <= '0;
      tvar_q    <= '{default: '0};
      tfree_q   <= '{default: '0};
      tassign_q <= '{default: '0};
      tflip_q   <= '0;
      tvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      free_q    <= free_d;
      assign_q  <= assign_d;
      bcp_req_q <= bcp_req_d;
      busy_q    <= busy_d;
      sat_q     <= sat_d;
      unsat_q   <= unsat_d;
      sp_q      <= sp_d;
      tvar_q    <= tvar_d;
      tfree_q   <= tfree_d;
      tassign_q <= tassign_d;
      tflip_q   <= tflip_d;
      tvalid_q  <= tvalid_d;
    end
  end

  assign free_out       = free_q;
  assign assignment_out = assign_q;
  assign bcp_request    = bcp_req_q;
  assign busy           = busy_q;
  assign sat            = sat_q;
  assign unsat          = unsat_q;

endmodule

// File: tb/tb_sat_decide_unit.sv
// Bench for sat_decide_unit: directed scenarios plus random solves checked against a
// queue-based DPLL trail model.
module tb_sat_decide_unit;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         bcp_done = 1'b0;
  logic         bcp_conflict = 1'b0;
  logic [N-1:0] free_in = '0;
  logic [N-1:0] assign_in = '0;
  logic [N-1:0] free_out, assignment_out;
  logic         bcp_request, busy, sat, unsat;

  int total = 0;
  int bad = 0;

  sat_decide_unit #(.VAR_NUM(N), .VAR_NUM_LOG(2)) dut (
    .clk(clk), .rst(rst), .start(start), .free_in(free_in), .assign_in(assign_in),
    .bcp_done(bcp_done), .bcp_conflict(bcp_conflict), .free_out(free_out),
    .assignment_out(assignment_out), .bcp_request(bcp_request), .busy(busy),
    .sat(sat), .unsat(unsat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       v;
    bit       flipped;
    bit [3:0] fs;
    bit [3:0] as;
  } ent_t;

  ent_t     trail[$];
  bit [3:0] m_free, m_assign;
  int       m_result;  // 0 running, 1 sat, 2 unsat

  function automatic void m_start(bit [3:0] f, bit [3:0] a);
    trail.delete();
    m_free = f;
    m_assign = a;
    m_result = 0;
  endfunction

  function automatic void m_decide();
    ent_t e;
    if (m_free == 0) begin
      m_result = 1;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (m_free[i]) begin
        e.v = i; e.flipped = 0; e.fs = m_free; e.as = m_assign;
        trail.push_back(e);
        m_free[i] = 1'b0;
        m_assign[i] = 1'b1;
        return;
      end
    end
  endfunction

  function automatic void m_backtrack();
    ent_t e;
    while (trail.size() > 0 && trail[trail.size()-1].flipped) void'(trail.pop_back());
    if (trail.size() == 0) begin
      m_result = 2;
    end else begin
      e = trail.pop_back();
      e.flipped = 1;
      trail.push_back(e);
      m_free = e.fs;     m_free[e.v] = 1'b0;
      m_assign = e.as;   m_assign[e.v] = 1'b0;
    end
  endfunction

  // Advances until a request or a final verdict appears; pulses are dropped after one cycle.
  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      bcp_done = 1'b0;
      cyc++;
    end while (!(bcp_request || sat || unsat) && cyc < 40);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({free_out, assignment_out, bcp_request, busy, sat, unsat} !== 12'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {free_out, assignment_out, bcp_request, busy, sat, unsat});
    end
    total++;
    if (dut.sp_q !== 3'd0 || dut.tvalid_q !== 4'b0) begin
      bad++; $display("FAIL reset_trail: got sp=%0d valid=%b want sp=0 valid=0000", dut.sp_q, dut.tvalid_q);
    end
    rst = 1'b1;
  endtask

  task automatic test_decide();
    @(negedge clk);
    free_in = 4'b1110; assign_in = 4'b1010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({busy, bcp_request} !== 2'b10) begin
      bad++; $display("FAIL decide_busy: got busy,req=%b want 10", {busy, bcp_request});
    end
    @(negedge clk);
    total++;
    if ({bcp_request, free_out, assignment_out} !== {1'b1, 4'b1100, 4'b1010}) begin
      bad++; $display("FAIL decide_outputs: got %b want 1_1100_1010", {bcp_request, free_out, assignment_out});
    end
    total++;
    if (dut.sp_q !== 3'd1) begin
      bad++; $display("FAIL decide_sp: got %0d want 1", dut.sp_q);
    end
    @(negedge clk);
    total++;
    if (bcp_request !== 1'b0) begin
      bad++; $display("FAIL decide_pulse: got %b want 0", bcp_request);
    end
    free_in = 4'b0000; assign_in = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if ({free_out, assignment_out, busy, sat} !== {4'b1100, 4'b1010, 1'b1, 1'b0}) begin
      bad++; $display("FAIL start_while_busy: got %b want 1100_1010_1_0", {free_out, assignment_out, busy, sat});
    end
  endtask

  task automatic test_sat();
    int cyc;
    bcp_done = 1'b1; bcp_conflict = 1'b0; free_in = 4'b0000; assign_in = 4'b1010;
    wait_out(cyc);
    total++;
    if (cyc !== 2 || {sat, busy, bcp_request, unsat} !== 4'b1000) begin
      bad++; $display("FAIL sat_result: got cyc=%0d sat,busy,req,unsat=%b want cyc=2 1000", cyc, {sat, busy, bcp_request, unsat});
    end
    bcp_done = 1'b1; bcp_conflict = 1'b1;
    @(negedge clk);
    bcp_done = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({sat, busy, bcp_request, unsat, free_out} !== {4'b1000, 4'b0000}) begin
      bad++; $display("FAIL done_ignored: got %b want 1000_0000", {sat, busy, bcp_request, unsat, free_out});
    end
  endtask

  task automatic test_conflict();
    int cyc;
    free_in = 4'b1110; assign_in = 4'b1010; start = 1'b1;
    wait_out(cyc);
    bcp_done = 1'b1; bcp_conflict = 1'b1;  // first WAIT_BCP cycle: must be ignored
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bcp_done = 1'b0;
      total++;
      if ({bcp_request, free_out, assignment_out} !== {1'b0, 4'b1100, 4'b1010}) begin
        bad++; $display("FAIL first_cycle_ignored: got %b want 0_1100_1010", {bcp_request, free_out, assignment_out});
      end
    end
    bcp_done = 1'b1; bcp_conflict = 1'b1;
    wait_out(cyc);
    total++;
    if ({bcp_request, free_out, assignment_out} !== {1'b1, 4'b1100, 4'b1000}) begin
      bad++; $display("FAIL flip_outputs: got %b want 1_1100_1000", {bcp_request, free_out, assignment_out});
    end
    total++;
    if (dut.tflip_q[0] !== 1'b1 || dut.sp_q !== 3'd1) begin
      bad++; $display("FAIL flip_trail: got flipped=%b sp=%0d want 1 1", dut.tflip_q[0], dut.sp_q);
    end
    @(negedge clk);
    bcp_done = 1'b1; bcp_conflict = 1'b1;
    wait_out(cyc);
    total++;
    if ({unsat, sat, busy, bcp_request} !== 4'b1000 || dut.sp_q !== 3'd0) begin
      bad++; $display("FAIL unsat_result: got unsat,sat,busy,req=%b sp=%0d want 1000 0", {unsat, sat, busy, bcp_request}, dut.sp_q);
    end
  endtask

  task automatic test_chain();
    int cyc;
    free_in = 4'b0011; assign_in = 4'b0000; start = 1'b1;
    wait_out(cyc);
    total++;
    if ({bcp_request, free_out, assignment_out} !== {1'b1, 4'b0010, 4'b0001}) begin
      bad++; $display("FAIL chain_v0: got %b want 1_0010_0001", {bcp_request, free_out, assignment_out});
    end
    @(negedge clk);
    bcp_done = 1'b1; bcp_conflict = 1'b0; free_in = 4'b0010; assign_in = 4'b0001;
    wait_out(cyc);
    total++;
    if ({bcp_request, free_out, assignment_out} !== {1'b1, 4'b0000, 4'b0011}) begin
      bad++; $display("FAIL chain_v1: got %b want 1_0000_0011", {bcp_request, free_out, assignment_out});
    end
    @(negedge clk);
    bcp_done = 1'b1; bcp_conflict = 1'b1;
    wait_out(cyc);
    total++;
    if ({bcp_request, free_out, assignment_out} !== {1'b1, 4'b0000, 4'b0001}) begin
      bad++; $display("FAIL chain_flip_v1: got %b want 1_0000_0001", {bcp_request, free_out, assignment_out});
    end
    @(negedge clk);
    bcp_done = 1'b1; bcp_conflict = 1'b1;
    wait_out(cyc);
    total++;
    if ({bcp_request, free_out, assignment_out} !== {1'b1, 4'b0010, 4'b0000} || dut.sp_q !== 3'd1) begin
      bad++; $display("FAIL chain_flip_v0: got %b sp=%0d want 1_0010_0000 sp=1", {bcp_request, free_out, assignment_out}, dut.sp_q);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({free_out, assignment_out, bcp_request, busy, sat, unsat} !== 12'b0) begin
      bad++; $display("FAIL async_reset: got %b want 0", {free_out, assignment_out, bcp_request, busy, sat, unsat});
    end
    @(negedge clk);
    rst = 1'b1;
    bcp_done = 1'b1; bcp_conflict = 1'b0; free_in = 4'b1111; assign_in = 4'b1111;
    @(negedge clk);
    bcp_done = 1'b0;
    @(negedge clk);
    total++;
    if ({free_out, assignment_out, bcp_request, busy, sat, unsat} !== 12'b0) begin
      bad++; $display("FAIL done_after_reset: got %b want 0", {free_out, assignment_out, bcp_request, busy, sat, unsat});
    end
    free_in = 4'b0100; assign_in = 4'b0000; start = 1'b1;
    wait_out(cyc);
    total++;
    if (cyc !== 2 || {bcp_request, busy, free_out, assignment_out} !== {2'b11, 4'b0000, 4'b0100}) begin
      bad++; $display("FAIL restart: got cyc=%0d %b want cyc=2 11_0000_0100", cyc, {bcp_request, busy, free_out, assignment_out});
    end
  endtask

  task automatic test_random();
    int       cyc, steps;
    bit [3:0] f, a, keep, freed, rnd;
    bit       conf;
    for (int r = 0; r < 30; r++) begin
      if (busy) begin
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
      end
      f = 4'($urandom); a = 4'($urandom);
      m_start(f, a);
      @(negedge clk);
      free_in = f; assign_in = a; start = 1'b1;
      m_decide();
      conf = 0; steps = 0;
      while (1) begin
        wait_out(cyc);
        if (!conf) begin
          total++;
          if (cyc !== 2) begin
            bad++; $display("FAIL rand_latency: run %0d got %0d cycles want 2", r, cyc);
          end
        end
        if (m_result == 1) begin
          total++;
          if ({sat, unsat, busy} !== 3'b100) begin
            bad++; $display("FAIL rand_sat: run %0d got sat,unsat,busy=%b want 100", r, {sat, unsat, busy});
          end
          break;
        end
        if (m_result == 2) begin
          total++;
          if ({sat, unsat, busy} !== 3'b010) begin
            bad++; $display("FAIL rand_unsat: run %0d got sat,unsat,busy=%b want 010", r, {sat, unsat, busy});
          end
          break;
        end
        total++;
        if ({bcp_request, free_out, assignment_out} !== {1'b1, m_free, m_assign}) begin
          bad++; $display("FAIL rand_step: run %0d got %b want 1_%b_%b", r, {bcp_request, free_out, assignment_out}, m_free, m_assign);
        end
        total++;
        if (dut.sp_q !== 3'(trail.size()) || dut.sp_q > 3'(N)) begin
          bad++; $display("FAIL rand_sp: run %0d got %0d want %0d (max %0d)", r, dut.sp_q, trail.size(), N);
        end
        steps++;
        if (!bcp_request || steps > 200) begin
          bad++; total++; $display("FAIL rand_stall: run %0d step %0d no request", r, steps);
          break;
        end
        repeat ($urandom_range(1, 3)) @(negedge clk);
        conf = 1'($urandom);
        bcp_done = 1'b1; bcp_conflict = conf;
        if (conf) begin
          m_backtrack();
        end else begin
          keep = 4'($urandom); rnd = 4'($urandom);
          free_in = m_free & keep;
          freed = m_free & ~free_in;
          assign_in = (m_assign & ~freed) | (rnd & freed);
          m_free = free_in; m_assign = assign_in;
          m_decide();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decide();
    test_sat();
    test_conflict();
    test_chain();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
